// File: rtl/coincidence_sync.sv
// coincidence_sync: pairs gie/gie2 rising edges into confirmed events,
// learns the event period, locks after repeated equal intervals and
// flywheels a one-cycle frame marker across missed events.
module coincidence_sync #(
  parameter int unsigned WIN      = 3,
  parameter int unsigned TOL      = 1,
  parameter int unsigned VERIFY_N = 3,
  parameter int unsigned MISS_N   = 2,
  parameter int unsigned PW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gie,
  input  logic          gie2,
  output logic          lock,
  output logic          frame_pulse,
  output logic          err,
  output logic [PW-1:0] period,
  output logic [7:0]    hit_cnt
);

  localparam int unsigned WW = $clog2(WIN + 2);
  localparam int unsigned VW = $clog2(VERIFY_N + 2);
  localparam int unsigned MW = $clog2(MISS_N + 2);
  // Two spare bits so period + TOL and tmr + TOL never wrap.
  localparam int unsigned XW = PW + 2;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  // Edge detect and pairing window
  logic          r_gie_d;
  logic          r_gie2_d;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_nxt;
  logic          w_gie_rise;
  logic          w_gie2_rise;
  logic          w_win_open;
  logic          w_evt;
  logic          w_pair_err;

  // Period tracking FSM
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_tmr;
  logic [PW-1:0] w_tmr_nxt;
  logic [PW-1:0] w_tmr_inc;
  logic          w_tmr_sat;
  logic [PW-1:0] r_period;
  logic [PW-1:0] w_period_nxt;
  logic [VW-1:0] r_vcnt;
  logic [VW-1:0] w_vcnt_nxt;
  logic [MW-1:0] r_miss;
  logic [MW-1:0] w_miss_nxt;
  logic [7:0]    r_hit_cnt;
  logic [7:0]    w_hit_cnt_nxt;
  logic          r_lock;
  logic          r_fp;
  logic          w_fp_nxt;
  logic          r_err;
  logic          w_err_nxt;

  // Interval comparisons against the learned period
  logic [XW-1:0] w_tmr_x;
  logic [XW-1:0] w_per_x;
  logic [XW-1:0] w_tol_x;
  logic          w_in_tol;
  logic          w_early;
  logic          w_miss_pt;

  assign lock        = r_lock;
  assign frame_pulse = r_fp;
  assign err         = r_err;
  assign period      = r_period;
  assign hit_cnt     = r_hit_cnt;

  // Rising edges, window state and event confirmation
  always_comb begin
    w_gie_rise  = gie & ~r_gie_d;
    w_gie2_rise = gie2 & ~r_gie2_d;
    w_win_open  = (r_wcnt != '0);
    w_evt       = w_gie2_rise & (w_gie_rise | w_win_open);
    w_pair_err  = w_gie_rise & w_win_open & ~w_evt;
    w_wcnt_nxt  = r_wcnt;
    if (w_evt) begin
      w_wcnt_nxt = '0;
    end else if (w_gie_rise) begin
      w_wcnt_nxt = WW'(WIN);
    end else if (w_win_open) begin
      w_wcnt_nxt = r_wcnt - WW'(1);
    end
  end

  // Input delay registers and pairing window counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gie_d  <= 1'b0;
      r_gie2_d <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_gie_d  <= gie;
      r_gie2_d <= gie2;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  // Timer helpers and tolerance tests on the current interval
  always_comb begin
    w_tmr_sat = (r_tmr == '1);
    w_tmr_inc = w_tmr_sat ? r_tmr : r_tmr + PW'(1);
    w_tmr_x   = XW'(r_tmr);
    w_per_x   = XW'(r_period);
    w_tol_x   = XW'(TOL);
    w_in_tol  = ((w_tmr_x + w_tol_x) >= w_per_x) && (w_tmr_x <= (w_per_x + w_tol_x));
    w_early   = (w_tmr_x + w_tol_x) < w_per_x;
    w_miss_pt = (w_tmr_x == (w_per_x + w_tol_x));
  end

  // Next-state and output decode for SEARCH / VERIFY / LOCK
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = w_tmr_inc;
    w_period_nxt  = r_period;
    w_vcnt_nxt    = r_vcnt;
    w_miss_nxt    = r_miss;
    w_hit_cnt_nxt = r_hit_cnt;
    w_fp_nxt      = 1'b0;
    w_err_nxt     = w_pair_err;
    case (r_state)
      S_SEARCH: begin
        if (w_evt) begin
          w_tmr_nxt   = PW'(1);
          w_vcnt_nxt  = '0;
          w_state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (w_evt) begin
          w_tmr_nxt = PW'(1);
        end
        if (w_tmr_sat) begin
          w_state_nxt = S_SEARCH;
        end else if (w_evt) begin
          if ((r_vcnt == '0) || !w_in_tol) begin
            w_period_nxt = r_tmr;
            w_vcnt_nxt   = VW'(1);
          end else begin
            w_vcnt_nxt = r_vcnt + VW'(1);
          end
          if (w_vcnt_nxt == VW'(VERIFY_N)) begin
            w_state_nxt   = S_LOCK;
            w_hit_cnt_nxt = '0;
            w_miss_nxt    = '0;
          end
        end
      end
      S_LOCK: begin
        // An event at the miss point is in tolerance, so the hit branch wins.
        if (w_evt && w_in_tol) begin
          w_fp_nxt      = 1'b1;
          w_hit_cnt_nxt = (r_hit_cnt == 8'hFF) ? r_hit_cnt : r_hit_cnt + 8'd1;
          w_miss_nxt    = '0;
          w_tmr_nxt     = PW'(1);
        end else if (w_evt && w_early) begin
          w_err_nxt = 1'b1;
        end else if (!w_evt && w_miss_pt) begin
          w_miss_nxt = r_miss + MW'(1);
          if (w_miss_nxt < MW'(MISS_N)) begin
            w_fp_nxt  = 1'b1;
            // Realign to the ideal frame edge, TOL cycles ago.
            w_tmr_nxt = PW'(TOL + 1);
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_SEARCH;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_SEARCH;
      r_tmr     <= '0;
      r_period  <= '0;
      r_vcnt    <= '0;
      r_miss    <= '0;
      r_hit_cnt <= '0;
      r_lock    <= 1'b0;
      r_fp      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_period  <= w_period_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_miss    <= w_miss_nxt;
      r_hit_cnt <= w_hit_cnt_nxt;
      r_lock    <= (w_state_nxt == S_LOCK);
      r_fp      <= w_fp_nxt;
      r_err     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_coincidence_sync.sv
// Testbench for coincidence_sync: directed scenarios plus randomized event
// streams, all checked cycle by cycle against a timestamp-based model.
module tb_coincidence_sync;

  localparam int WIN      = 3;
  localparam int TOL      = 1;
  localparam int VERIFY_N = 3;
  localparam int MISS_N   = 2;
  localparam int PW       = 8;
  localparam int TMAX     = (1 << PW) - 1;
  localparam int L        = 1200;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          gie  = 1'b0;
  logic          gie2 = 1'b0;
  logic          lock;
  logic          frame_pulse;
  logic          err;
  logic [PW-1:0] period;
  logic [7:0]    hit_cnt;

  always #5 clk = ~clk;

  coincidence_sync #(
    .WIN(WIN),
    .TOL(TOL),
    .VERIFY_N(VERIFY_N),
    .MISS_N(MISS_N),
    .PW(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gie(gie),
    .gie2(gie2),
    .lock(lock),
    .frame_pulse(frame_pulse),
    .err(err),
    .period(period),
    .hit_cnt(hit_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: time is the absolute edge index; the interval timer is derived
  // from the edge at which it last read zero (m_ref).
  int m_k      = 0;
  bit m_gp     = 0;
  bit m_g2p    = 0;
  bit m_wopen  = 0;
  int m_wstart = 0;
  int m_ref    = 1;
  bit m_locked = 0;
  bit m_verif  = 0;
  int m_nint   = 0;
  int m_period = 0;
  int m_hits   = 0;
  int m_miss   = 0;
  bit m_fp     = 0;
  bit m_err    = 0;

  bit sg  [L];
  bit sg2 [L];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, m_k, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit g, input bit g2);
    bit grise, g2rise, inwin, evt, intol, early;
    int t;
    if (r) begin
      m_gp = 0; m_g2p = 0; m_wopen = 0; m_wstart = 0;
      m_ref = m_k + 1;
      m_locked = 0; m_verif = 0; m_nint = 0;
      m_period = 0; m_hits = 0; m_miss = 0;
      m_fp = 0; m_err = 0;
    end else begin
      grise  = g && !m_gp;
      g2rise = g2 && !m_g2p;
      inwin  = m_wopen && ((m_k - m_wstart) <= WIN);
      evt    = g2rise && (grise || inwin);
      m_err  = grise && inwin && !evt;
      m_fp   = 0;
      if (evt) m_wopen = 0;
      else if (grise) begin
        m_wopen  = 1;
        m_wstart = m_k;
      end
      t = m_k - m_ref;
      if (t > TMAX) t = TMAX;
      intol = ((t - m_period) <= TOL) && ((m_period - t) <= TOL);
      early = t < (m_period - TOL);
      if (m_locked) begin
        if (evt && intol) begin
          m_fp = 1;
          if (m_hits < 255) m_hits++;
          m_miss = 0;
          m_ref  = m_k;
        end else if (evt && early) begin
          m_err = 1;
        end else if (!evt && (t == m_period + TOL)) begin
          m_miss++;
          if (m_miss < MISS_N) begin
            m_fp  = 1;
            m_ref = m_k - TOL;
          end else begin
            m_locked = 0;
          end
        end
      end else if (m_verif) begin
        if (evt) m_ref = m_k;
        if (t == TMAX) begin
          m_verif = 0;
        end else if (evt) begin
          if (m_nint == 0 || !intol) begin
            m_period = t;
            m_nint   = 1;
          end else begin
            m_nint++;
          end
          if (m_nint == VERIFY_N) begin
            m_verif  = 0;
            m_locked = 1;
            m_hits   = 0;
            m_miss   = 0;
          end
        end
      end else if (evt) begin
        m_ref   = m_k;
        m_verif = 1;
        m_nint  = 0;
      end
      m_gp  = g;
      m_g2p = g2;
    end
    m_k++;
  endtask

  task automatic cycle(input bit r, input bit g, input bit g2);
    rst  = r;
    gie  = g;
    gie2 = g2;
    model_step(r, g, g2);
    @(posedge clk);
    @(negedge clk);
    check("lock", lock, 32'(m_locked));
    check("frame_pulse", frame_pulse, 32'(m_fp));
    check("err", err, 32'(m_err));
    check("period", 32'(period), 32'(m_period));
    check("hit_cnt", 32'(hit_cnt), 32'(m_hits));
  endtask

  task automatic reset_and_check(input string tag);
    cycle(1, 1'($urandom), 1'($urandom));
    check({tag, "_lock"}, lock, 0);
    check({tag, "_fp"}, frame_pulse, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
  endtask

  // gie rises at edge 10+20n, gie2 at 12+20n, n = 0..5 (edges counted from 1)
  task automatic scen2(input int last_e, input bit chk);
    for (int e = 1; e <= last_e; e++) begin
      bit g, g2;
      g  = 0;
      g2 = 0;
      if (e >= 10 && ((e - 10) / 20) <= 5 && ((e - 10) % 20) < 5) g = 1;
      if (e >= 12 && ((e - 12) / 20) <= 5 && ((e - 12) % 20) < 5) g2 = 1;
      cycle(0, g, g2);
      if (chk) begin
        if (e == 31)  check("s2_period_pre", 32'(period), 0);
        if (e == 32)  check("s2_period", 32'(period), 20);
        if (e == 71)  check("s2_lock_pre", lock, 0);
        if (e == 72)  check("s2_lock_rise", lock, 1);
        if (e == 72)  check("s2_fp_at_lock", frame_pulse, 0);
        if (e == 92)  check("s2_fp_92", frame_pulse, 1);
        if (e == 93)  check("s2_fp_width", frame_pulse, 0);
        if (e == 112) check("s2_fp_112", frame_pulse, 1);
        if (e == 113) check("s2_hit_cnt", 32'(hit_cnt), 2);
        if (e == 133) check("s2_flywheel_fp", frame_pulse, 1);
        if (e == 133) check("s2_flywheel_lock", lock, 1);
        if (e == 152) check("s2_lock_hold", lock, 1);
        if (e == 153) check("s2_lock_fall", lock, 0);
        if (e == 153) check("s2_no_fp_at_loss", frame_pulse, 0);
        if (e == 160) check("s2_period_hold", 32'(period), 20);
      end
    end
  endtask

  task automatic pulses(input int per, input int off, input int count);
    for (int n = 0; n < count; n++)
      for (int j = 0; j < per; j++)
        cycle(0, (j < 2), (j >= off) && (j < off + 2));
  endtask

  task automatic fire(input int gap);
    for (int i = 1; i < gap; i++) cycle(0, 0, 0);
    cycle(0, 1, 1);
  endtask

  task automatic random_block();
    int p, t, j, off, wg, w2, r2, s;
    p = int'($urandom_range(30, 8));
    for (int i = 0; i < L; i++) begin
      sg[i]  = 0;
      sg2[i] = 0;
    end
    t = int'($urandom_range(5, 0));
    while (t < L - 40) begin
      r2 = int'($urandom_range(99, 0));
      if (r2 >= 8) begin
        off = int'($urandom_range(4, 0));
        wg  = int'($urandom_range(3, 1));
        w2  = int'($urandom_range(3, 1));
        for (int i = 0; i < wg; i++) sg[t + i] = 1;
        for (int i = 0; i < w2; i++) sg2[t + off + i] = 1;
      end
      if (r2 >= 8 && r2 < 16) begin
        s = t + p / 2;
        sg[s]  = 1;
        sg2[s] = 1;
      end
      if (r2 >= 16 && r2 < 22) begin
        s = t + int'($urandom_range(6, 2));
        sg[s] = 1;
      end
      r2 = int'($urandom_range(99, 0));
      if (r2 < 70)      j = 0;
      else if (r2 < 90) j = int'($urandom_range(2, 0)) - 1;
      else              j = int'($urandom_range(10, 0)) - 5;
      t = t + p + j;
    end
    for (int i = 0; i < L; i++)
      cycle(($urandom_range(599, 0) == 0), sg[i], sg2[i]);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_and_check("rst1");
    reset_and_check("rst2");

    scen2(160, 1);

    // Window boundary: offset 4 never confirms, offset 3 does
    reset_and_check("rst_win");
    pulses(20, 4, 6);
    check("win_reject_lock", lock, 0);
    check("win_reject_period", 32'(period), 0);
    pulses(20, 3, 4);
    check("win_accept_lock", lock, 1);
    check("win_accept_period", 32'(period), 20);

    // Tolerance, spurious event, flywheel and loss of lock
    reset_and_check("rst_tol");
    fire(20); fire(20); fire(20);
    check("tol_lock_pre", lock, 0);
    fire(20);
    check("tol_lock", lock, 1);
    fire(19);
    check("tol_hit19", frame_pulse, 1);
    fire(21);
    check("tol_hit21", frame_pulse, 1);
    fire(15);
    check("tol_spur_err", err, 1);
    check("tol_spur_fp", frame_pulse, 0);
    fire(5);
    check("tol_after_spur", frame_pulse, 1);
    check("tol_after_spur_err", err, 0);
    fire(40);
    check("fly_hit", frame_pulse, 1);
    check("fly_lock", lock, 1);
    fire(80);
    check("loss_lock", lock, 0);
    check("loss_fp", frame_pulse, 0);
    check("loss_hit_cnt", 32'(hit_cnt), 4);

    // Reset mid-lock, then reacquire with the same timing
    reset_and_check("rst_pre");
    scen2(100, 0);
    check("midlock_locked", lock, 1);
    reset_and_check("rst_mid");
    scen2(160, 1);

    for (int b = 0; b < 8; b++) begin
      reset_and_check("rst_rand");
      random_block();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
